decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Consumes the fetched instruction word and its PC, decodes RV32I-format fields, reads the register file and generates the sign-extended immediate.
- Detects load-use hazards and registers the decoded bundle into the ID/EX pipeline register for the execute stage.
- Owns the architectural register file; the writeback port enters here.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers (x0 hardwired zero).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instruction_dec  in  32  instruction word from fetch
- pc_dec  in  32  PC associated with instruction_dec
- flush  in  1  branch taken / interrupt redirect; kill the instruction in decode
- wb_en  in  1  register write enable from writeback
- wb_rd  in  5  writeback destination register
- wb_data  in  32  writeback data
- stall_fe  out  1  combinational; fetch must hold PC and instruction_dec this cycle
- valid_ex  out  1  ID/EX holds a live instruction
- pc_ex  out  32  registered PC
- rs1_data_ex  out  32  registered rs1 operand
- rs2_data_ex  out  32  registered rs2 operand
- imm_ex  out  32  registered sign-extended immediate
- rd_ex  out  5  registered destination register
- ctrl_ex  out  ctrl_t  registered control bundle: alu_op, alu_src_imm, mem_rd, mem_wr, reg_wr, branch, jump, rti, rsi
- illegal_ex  out  1  registered illegal-opcode flag

Behaviour:
- Reset:
  - All *_ex outputs, valid_ex and illegal_ex are 0.
  - ctrl_ex is all-zero (NOP).
  - All register file entries are 0.
- Latency: 1 cycle. Fields decoded in cycle N appear on *_ex at the rising edge ending cycle N.
- Register file:
  - 2 combinational read ports, 1 synchronous write port.
  - Reads of x0 return 0; writes to x0 are ignored.
  - Write-through: if wb_en and wb_rd == rsX != 0, the read returns wb_data in the same cycle.
- Immediate generation:
  - I, S, B, U and J formats per the RV32I bit layout; sign bit is instruction[31].
  - B and J immediates have bit 0 = 0.
  - R-type immediate is 0.
- Source-use flags: uses_rs1 / uses_rs2 are derived from the opcode. Unused source fields never cause a stall.
- Load-use hazard:
  - stall_fe = valid_ex & ctrl_ex.mem_rd & (rd_ex != 0) & ((uses_rs1 & rs1 == rd_ex) | (uses_rs2 & rs2 == rd_ex)) & ~flush.
  - On a stall, the ID/EX register loads a bubble: valid_ex = 0, ctrl_ex = NOP, rd_ex = 0, illegal_ex = 0.
  - The next cycle re-decodes the held instruction.
- Flush:
  - flush = 1 loads a bubble into ID/EX at the next edge, regardless of instruction_dec.
  - flush has priority over stall; stall_fe is forced to 0 while flush is asserted.
- Illegal opcode:
  - Any opcode outside the decoded set sets illegal_ex = 1 with a NOP ctrl_ex.
  - valid_ex = 1 in this case so execute can raise an exception.
- instruction_dec == 32'h0 (fetch reset/bubble value) decodes as a bubble: valid_ex = 0, illegal_ex = 0.
- Simultaneous events:
  - A writeback to the same rd as a stalled instruction's source is captured through the write-through path on the re-decode cycle.
  - wb and flush are independent; a writeback is never blocked.
- Reset mid-operation: asynchronous clear of ID/EX and the register file; stall_fe is 0 while rst_n is low.

Decomposition:
- proc_pkg shared package:
  - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS
  - alu_op_t enum
  - ctrl_t packed struct
  - NOP_CTRL constant
- One sub-module: reg_file (NREGS x XLEN, 2R1W, write-through, x0 hardwired). All decode, immediate and hazard logic stays in decode_stage.

Test Plan:
- Reset then clock with instruction_dec = 32'h0 -> valid_ex = 0, ctrl_ex = NOP, rs1_data_ex = 0.
- Writeback x5 = 32'h1234_5678, then decode addi x6,x5,-1 (32'hFFF28313) -> rs1_data_ex = 32'h12345678, imm_ex = 32'hFFFFFFFF, rd_ex = 6, reg_wr = 1.
- Same cycle: wb_en, wb_rd = 7, wb_data = 32'hA5A5A5A5 while decoding add x8,x7,x0 -> rs1_data_ex = 32'hA5A5A5A5 (write-through); a write to x0 leaves x0 reads at 0.
- Load-use: lw x3,0(x2) in ID/EX and add x4,x3,x1 in decode -> stall_fe = 1 for one cycle, bubble on valid_ex, then add issues with valid_ex = 1; sw x3 where rs2 = x3 also stalls; lui x3 does not stall.
- flush asserted with a load-use condition present -> stall_fe = 0, next valid_ex = 0.
- beq with B-imm -8 (32'hFE000CE3) -> imm_ex = 32'hFFFFFFF8; opcode 7'b1111111 -> illegal_ex = 1, valid_ex = 1, ctrl_ex = NOP.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation encoding and the
// control bundle carried from decode into execute.
package proc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    // rti: return from interrupt (mret); rsi: other system ops that trap
    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src_imm;
        logic    mem_rd;
        logic    mem_wr;
        logic    reg_wr;
        logic    branch;
        logic    jump;
        logic    rti;
        logic    rsi;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = ctrl_t'('0);

    // Only register-register ops use funct7[5] to select SUB; shifts use it for SRA
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3,
                                               input logic funct7_b5,
                                               input logic is_reg);
        alu_op_t op;
        case (funct3)
            3'd0:    op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port with write-through, x0 hardwired to zero.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != 5'd0) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A same-cycle writeback is forwarded so decode never sees a stale operand
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = (wr_en && wr_addr == rs1_addr) ? wr_data : regs_q[rs1_addr];
        end
        if (rs2_addr != 5'd0) begin
            rs2_data = (wr_en && wr_addr == rs2_addr) ? wr_data : regs_q[rs2_addr];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field decode, immediate generation, register read,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
    import proc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction_dec,
    input  logic [31:0]     pc_dec,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_fe,
    output logic            valid_ex,
    output logic [31:0]     pc_ex,
    output logic [XLEN-1:0] rs1_data_ex,
    output logic [XLEN-1:0] rs2_data_ex,
    output logic [31:0]     imm_ex,
    output logic [4:0]      rd_ex,
    output ctrl_t           ctrl_ex,
    output logic            illegal_ex
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_rdata, rs2_rdata;

    assign opcode = instruction_dec[6:0];
    assign rd     = instruction_dec[11:7];
    assign funct3 = instruction_dec[14:12];
    assign rs1    = instruction_dec[19:15];
    assign rs2    = instruction_dec[24:20];

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_rdata),
        .rs2_data (rs2_rdata),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rd_q, rd_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        illegal_q, illegal_d;

    ctrl_t       ctrl;
    logic [31:0] imm;
    logic        uses_rs1, uses_rs2, legal;

    always_comb begin
        ctrl     = NOP_CTRL;
        imm      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_R: begin
                ctrl.alu_op = alu_from_funct(funct3, instruction_dec[30], 1'b1);
                ctrl.reg_wr = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_I: begin
                ctrl.alu_op      = alu_from_funct(funct3, instruction_dec[30], 1'b0);
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_wr      = 1'b1;
                imm              = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
                uses_rs1         = 1'b1;
            end
            OP_LOAD: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_rd      = 1'b1;
                ctrl.reg_wr      = 1'b1;
                imm              = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
                uses_rs1         = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_wr      = 1'b1;
                imm              = {{20{instruction_dec[31]}}, instruction_dec[31:25],
                                    instruction_dec[11:7]};
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                imm         = {{19{instruction_dec[31]}}, instruction_dec[31], instruction_dec[7],
                               instruction_dec[30:25], instruction_dec[11:8], 1'b0};
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump   = 1'b1;
                ctrl.reg_wr = 1'b1;
                imm         = {{11{instruction_dec[31]}}, instruction_dec[31], instruction_dec[19:12],
                               instruction_dec[20], instruction_dec[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.jump        = 1'b1;
                ctrl.reg_wr      = 1'b1;
                imm              = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
                uses_rs1         = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_op      = ALU_LUI;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_wr      = 1'b1;
                imm              = {instruction_dec[31:12], 12'b0};
            end
            OP_AUIPC: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_wr      = 1'b1;
                imm              = {instruction_dec[31:12], 12'b0};
            end
            OP_SYS: begin
                imm      = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
                ctrl.rti = (instruction_dec[31:20] == 12'h302) && (funct3 == 3'd0);
                ctrl.rsi = !ctrl.rti;
            end
            default: legal = 1'b0;
        endcase
    end

    logic load_use, bubble;

    assign load_use = valid_q && ctrl_q.mem_rd && (rd_q != 5'd0) &&
                      ((uses_rs1 && rs1 == rd_q) || (uses_rs2 && rs2 == rd_q));
    assign stall_fe = rst_n && load_use && !flush;
    assign bubble   = flush || load_use || (instruction_dec == 32'h0);

    // Bubbles clear the whole bundle so execute sees a clean NOP
    always_comb begin
        valid_d    = 1'b0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rd_d       = '0;
        ctrl_d     = NOP_CTRL;
        illegal_d  = 1'b0;
        if (!bubble) begin
            valid_d    = 1'b1;
            pc_d       = pc_dec;
            rs1_data_d = rs1_rdata;
            rs2_data_d = rs2_rdata;
            imm_d      = imm;
            rd_d       = ctrl.reg_wr ? rd : 5'd0;
            ctrl_d     = ctrl;
            illegal_d  = !legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= NOP_CTRL;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

    assign valid_ex    = valid_q;
    assign pc_ex       = pc_q;
    assign rs1_data_ex = rs1_data_q;
    assign rs2_data_ex = rs2_data_q;
    assign imm_ex      = imm_q;
    assign rd_ex       = rd_q;
    assign ctrl_ex     = ctrl_q;
    assign illegal_ex  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of single-cycle decode vectors plus
// hand-written load-use, flush and mid-operation reset sequences.
module tb_decode_stage;
    import proc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction_dec;
    logic [31:0] pc_dec;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_fe;
    logic        valid_ex;
    logic [31:0] pc_ex;
    logic [31:0] rs1_data_ex;
    logic [31:0] rs2_data_ex;
    logic [31:0] imm_ex;
    logic [4:0]  rd_ex;
    ctrl_t       ctrl_ex;
    logic        illegal_ex;

    decode_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instruction_dec (instruction_dec),
        .pc_dec          (pc_dec),
        .flush           (flush),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .stall_fe        (stall_fe),
        .valid_ex        (valid_ex),
        .pc_ex           (pc_ex),
        .rs1_data_ex     (rs1_data_ex),
        .rs2_data_ex     (rs2_data_ex),
        .imm_ex          (imm_ex),
        .rd_ex           (rd_ex),
        .ctrl_ex         (ctrl_ex),
        .illegal_ex      (illegal_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        exp_t        exp;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam exp_t BUB = '0;

    function automatic ctrl_t mkc(input alu_op_t op, input logic src_imm, mrd, mwr, rwr,
                                  br, jmp, rti, rsi);
        ctrl_t c;
        c.alu_op      = op;
        c.alu_src_imm = src_imm;
        c.mem_rd      = mrd;
        c.mem_wr      = mwr;
        c.reg_wr      = rwr;
        c.branch      = br;
        c.jump        = jmp;
        c.rti         = rti;
        c.rsi         = rsi;
        return c;
    endfunction

    function automatic exp_t mke(input logic v, input logic [31:0] pc, r1, r2, im,
                                 input logic [4:0] rd, input ctrl_t c, input logic ill);
        exp_t e;
        e.valid   = v;
        e.pc      = pc;
        e.rs1     = r1;
        e.rs2     = r2;
        e.imm     = im;
        e.rd      = rd;
        e.ctrl    = c;
        e.illegal = ill;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [31:0] ins, pc, input logic fl, we,
                                 input logic [4:0] wrd, input logic [31:0] wd, input exp_t e);
        vec_t v;
        v.instr   = ins;
        v.pc      = pc;
        v.flush   = fl;
        v.wb_en   = we;
        v.wb_rd   = wrd;
        v.wb_data = wd;
        v.exp     = e;
        return v;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_out(input exp_t e);
        check("valid_ex", 64'(valid_ex), 64'(e.valid));
        check("pc_ex", 64'(pc_ex), 64'(e.pc));
        check("rs1_data_ex", 64'(rs1_data_ex), 64'(e.rs1));
        check("rs2_data_ex", 64'(rs2_data_ex), 64'(e.rs2));
        check("imm_ex", 64'(imm_ex), 64'(e.imm));
        check("rd_ex", 64'(rd_ex), 64'(e.rd));
        check("ctrl_ex", 64'(ctrl_ex), 64'(e.ctrl));
        check("illegal_ex", 64'(illegal_ex), 64'(e.illegal));
    endtask

    // Drive one decode cycle, check stall_fe before the edge, compare ID/EX after it
    task automatic step(input logic [31:0] ins, pcv, input logic fl, we,
                        input logic [4:0] wrd, input logic [31:0] wd,
                        input logic exp_stall, input exp_t e);
        exp_t got;
        @(negedge clk);
        instruction_dec = ins;
        pc_dec          = pcv;
        flush           = fl;
        wb_en           = we;
        wb_rd           = wrd;
        wb_data         = wd;
        #1;
        check("stall_fe", 64'(stall_fe), 64'(exp_stall));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            got = exp_q.pop_front();
            compare_out(got);
        end
    endtask

    vec_t  vecs[17];
    ctrl_t c_r_add, c_r_sub, c_lw, c_sw;
    logic [31:0] lw_x3, add_x4, sw_x3, d;
    logic [4:0]  r;

    initial begin
        c_r_add = mkc(ALU_ADD, 0, 0, 0, 1, 0, 0, 0, 0);
        c_r_sub = mkc(ALU_SUB, 0, 0, 0, 1, 0, 0, 0, 0);
        c_lw    = mkc(ALU_ADD, 1, 1, 0, 1, 0, 0, 0, 0);
        c_sw    = mkc(ALU_ADD, 1, 0, 1, 0, 0, 0, 0, 0);
        lw_x3   = enc_i(12'h000, 5'd2, 3'd2, 5'd3, 7'b0000011);
        add_x4  = enc_r(7'h00, 5'd1, 5'd3, 3'd0, 5'd4);
        sw_x3   = enc_s(12'h000, 5'd3, 5'd0, 3'd2);

        vecs[0]  = mkv(32'h0, 32'h100, 0, 1, 5'd5, 32'h1234_5678, BUB);
        vecs[1]  = mkv(32'hFFF2_8313, 32'h104, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h104, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 5'd6,
                           mkc(ALU_ADD, 1, 0, 0, 1, 0, 0, 0, 0), 0));
        vecs[2]  = mkv(enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd8), 32'h108, 0, 1, 5'd7, 32'hA5A5_A5A5,
                       mke(1, 32'h108, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd8, c_r_add, 0));
        vecs[3]  = mkv(enc_r(7'h00, 5'd5, 5'd0, 3'd0, 5'd9), 32'h10C, 0, 1, 5'd0, 32'hDEAD_BEEF,
                       mke(1, 32'h10C, 32'h0, 32'h1234_5678, 32'h0, 5'd9, c_r_add, 0));
        vecs[4]  = mkv(enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd10), 32'h110, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h110, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd10, c_r_add, 0));
        vecs[5]  = mkv(32'hABCD_E1B7, 32'h114, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h114, 32'h0, 32'h0, 32'hABCD_E000, 5'd3,
                           mkc(ALU_LUI, 1, 0, 0, 1, 0, 0, 0, 0), 0));
        vecs[6]  = mkv(32'hFE00_0CE3, 32'h118, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h118, 32'h0, 32'h0, 32'hFFFF_FFF8, 5'd0,
                           mkc(ALU_SUB, 0, 0, 0, 0, 1, 0, 0, 0), 0));
        vecs[7]  = mkv(32'h0000_007F, 32'h11C, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h11C, 32'h0, 32'h0, 32'h0, 5'd0, NOP_CTRL, 1));
        vecs[8]  = mkv(enc_s(12'd12, 5'd5, 5'd7, 3'd2), 32'h120, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h120, 32'hA5A5_A5A5, 32'h1234_5678, 32'hC, 5'd0, c_sw, 0));
        vecs[9]  = mkv(32'h0010_00EF, 32'h124, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h124, 32'h0, 32'h0, 32'h800, 5'd1,
                           mkc(ALU_ADD, 0, 0, 0, 1, 0, 1, 0, 0), 0));
        vecs[10] = mkv(32'h0000_1597, 32'h128, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h128, 32'h0, 32'h0, 32'h1000, 5'd11,
                           mkc(ALU_ADD, 1, 0, 0, 1, 0, 0, 0, 0), 0));
        vecs[11] = mkv(enc_r(7'h20, 5'd5, 5'd7, 3'd0, 5'd12), 32'h12C, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h12C, 32'hA5A5_A5A5, 32'h1234_5678, 32'h0, 5'd12, c_r_sub, 0));
        vecs[12] = mkv(enc_i(12'h404, 5'd7, 3'd5, 5'd13, 7'b0010011), 32'h130, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h130, 32'hA5A5_A5A5, 32'h0, 32'h404, 5'd13,
                           mkc(ALU_SRA, 1, 0, 0, 1, 0, 0, 0, 0), 0));
        vecs[13] = mkv(32'hFFF2_8313, 32'h134, 1, 1, 5'd1, 32'h11, BUB);
        vecs[14] = mkv(32'h3020_0073, 32'h138, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h138, 32'h0, 32'h0, 32'h302, 5'd0,
                           mkc(ALU_ADD, 0, 0, 0, 0, 0, 0, 1, 0), 0));
        vecs[15] = mkv(32'h0000_0073, 32'h13C, 0, 0, 5'd0, 32'h0,
                       mke(1, 32'h13C, 32'h0, 32'h0, 32'h0, 5'd0,
                           mkc(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 1), 0));
        vecs[16] = mkv(32'h0, 32'h140, 0, 1, 5'd2, 32'h40, BUB);

        // Clock/reset
        rst_n           = 1'b0;
        instruction_dec = 32'h0;
        pc_dec          = 32'h0;
        flush           = 1'b0;
        wb_en           = 1'b0;
        wb_rd           = 5'd0;
        wb_data         = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        compare_out(BUB);
        check("stall_fe_reset", 64'(stall_fe), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single-cycle decode vectors
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].instr, vecs[i].pc, vecs[i].flush, vecs[i].wb_en,
                 vecs[i].wb_rd, vecs[i].wb_data, 1'b0, vecs[i].exp);
        end

        // Load-use on rs1, writeback to x3 lands during the re-decode
        step(lw_x3, 32'h200, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h200, 32'h40, 32'h0, 32'h0, 5'd3, c_lw, 0));
        step(add_x4, 32'h204, 0, 0, 5'd0, 32'h0, 1'b1, BUB);
        step(add_x4, 32'h204, 0, 1, 5'd3, 32'h77, 1'b0,
             mke(1, 32'h204, 32'h77, 32'h11, 32'h0, 5'd4, c_r_add, 0));

        // Load-use on rs2 of a store
        step(lw_x3, 32'h208, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h208, 32'h40, 32'h0, 32'h0, 5'd3, c_lw, 0));
        step(sw_x3, 32'h20C, 0, 0, 5'd0, 32'h0, 1'b1, BUB);
        step(sw_x3, 32'h20C, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h20C, 32'h0, 32'h77, 32'h0, 5'd0, c_sw, 0));

        // lui x3 has no source operands, so no stall behind the load
        step(lw_x3, 32'h210, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h210, 32'h40, 32'h0, 32'h0, 5'd3, c_lw, 0));
        step(32'h1234_51B7, 32'h214, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h214, 32'h0, 32'h77, 32'h1234_5000, 5'd3,
                 mkc(ALU_LUI, 1, 0, 0, 1, 0, 0, 0, 0), 0));

        // Flush overrides a pending load-use stall
        step(lw_x3, 32'h218, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h218, 32'h40, 32'h0, 32'h0, 5'd3, c_lw, 0));
        step(add_x4, 32'h21C, 1, 0, 5'd0, 32'h0, 1'b0, BUB);

        // Random writebacks read back through a following add
        for (int k = 0; k < 6; k++) begin
            r = 5'($urandom_range(16, 19));
            d = $urandom;
            step(32'h0, 32'h300, 0, 1, r, d, 1'b0, BUB);
            step(enc_r(7'h00, 5'd0, r, 3'd0, 5'd15), 32'h304, 0, 0, 5'd0, 32'h0, 1'b0,
                 mke(1, 32'h304, d, 32'h0, 32'h0, 5'd15, c_r_add, 0));
        end

        // Asynchronous reset in the middle of a stall
        step(lw_x3, 32'h400, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h400, 32'h40, 32'h0, 32'h0, 5'd3, c_lw, 0));
        @(negedge clk);
        instruction_dec = add_x4;
        pc_dec          = 32'h404;
        wb_en           = 1'b0;
        #1;
        check("stall_fe_pre_reset", 64'(stall_fe), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("stall_fe_in_reset", 64'(stall_fe), 64'(0));
        compare_out(BUB);
        @(negedge clk);
        rst_n           = 1'b1;
        instruction_dec = 32'h0;
        step(enc_r(7'h00, 5'd5, 5'd1, 3'd0, 5'd9), 32'h408, 0, 0, 5'd0, 32'h0, 1'b0,
             mke(1, 32'h408, 32'h0, 32'h0, 32'h0, 5'd9, c_r_add, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
